// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation modes and fill-width helper.
// The rotate modes are only decoded when SHREG_ROTATE_EN is defined.
package shreg_pkg;

    typedef enum logic [2:0] {
        SHREG_HOLD     = 3'b000,
        SHREG_SHIFT_UP = 3'b001,
        SHREG_SHIFT_DN = 3'b010,
        SHREG_LOAD     = 3'b011,
        SHREG_CLEAR    = 3'b100,
        SHREG_ROT_UP   = 3'b101,
        SHREG_ROT_DN   = 3'b110,
        SHREG_RSVD     = 3'b111
    } shreg_mode_e;

    // Bits needed to count 0..depth inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shreg_fill_ctr.sv
// Saturating fill-level counter for the universal shift register.
// Clear has priority over set-full, which has priority over increment.
module shreg_fill_ctr
    import shreg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FW    = fill_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_set_full,
    input  logic          i_clr,
    output logic [FW-1:0] o_fill,
    output logic          o_full
);

    localparam logic [FW-1:0] FULL_C = FW'(DEPTH);

    logic [FW-1:0] fill_r;
    logic [FW-1:0] fill_nxt_s;

    // Next fill value; increments stop at DEPTH so the count never wraps.
    always_comb begin
        fill_nxt_s = fill_r;
        if (i_clr) begin
            fill_nxt_s = {FW{1'b0}};
        end else if (i_set_full) begin
            fill_nxt_s = FULL_C;
        end else if (i_inc && (fill_r != FULL_C)) begin
            fill_nxt_s = fill_r + FW'(1);
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Fill register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_r <= {FW{1'b0}};
        end else begin
            fill_r <= fill_nxt_s;
        end
    end

    assign o_fill = fill_r;
    assign o_full = (fill_r == FULL_C);

endmodule

// File: rtl/shreg_univ.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, load, clear
// and (when SHREG_ROTATE_EN is defined) rotate modes, plus fill tracking.
module shreg_univ
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic [2:0]                   i_mode,
    input  logic [WIDTH-1:0]             i_d,
    input  logic [DEPTH*WIDTH-1:0]       i_pdata,
    output logic [DEPTH*WIDTH-1:0]       o_q,
    output logic [WIDTH-1:0]             o_sout,
    output logic [fill_width(DEPTH)-1:0] o_fill,
    output logic                         o_full
);

    localparam int FW = fill_width(DEPTH);

    // Stage k lives at index k, so the packed array lines up with i_pdata/o_q.
    logic [DEPTH-1:0][WIDTH-1:0] stage_r;
    logic [DEPTH-1:0][WIDTH-1:0] stage_nxt_s;
    logic [WIDTH-1:0]            sout_r;
    logic [WIDTH-1:0]            sout_nxt_s;
    logic                        inc_s;
    logic                        set_full_s;
    logic                        clr_s;
    shreg_mode_e                 mode_s;

    assign mode_s = shreg_mode_e'(i_mode);

    // Mode decode: next stage contents, shifted-out word and fill-counter controls.
    always_comb begin
        stage_nxt_s = stage_r;
        sout_nxt_s  = sout_r;
        inc_s       = 1'b0;
        set_full_s  = 1'b0;
        clr_s       = 1'b0;
        if (i_en) begin
            case (mode_s)
                SHREG_SHIFT_UP: begin
                    stage_nxt_s = {stage_r[DEPTH-2:0], i_d};
                    sout_nxt_s  = stage_r[DEPTH-1];
                    inc_s       = 1'b1;
                end
                SHREG_SHIFT_DN: begin
                    stage_nxt_s = {i_d, stage_r[DEPTH-1:1]};
                    sout_nxt_s  = stage_r[0];
                    inc_s       = 1'b1;
                end
                SHREG_LOAD: begin
                    stage_nxt_s = i_pdata;
                    set_full_s  = 1'b1;
                end
                SHREG_CLEAR: begin
                    stage_nxt_s = {(DEPTH*WIDTH){1'b0}};
                    sout_nxt_s  = {WIDTH{1'b0}};
                    clr_s       = 1'b1;
                end
`ifdef SHREG_ROTATE_EN
                SHREG_ROT_UP: begin
                    stage_nxt_s = {stage_r[DEPTH-2:0], stage_r[DEPTH-1]};
                end
                SHREG_ROT_DN: begin
                    stage_nxt_s = {stage_r[0], stage_r[DEPTH-1:1]};
                end
`else
                SHREG_ROT_UP, SHREG_ROT_DN: begin
                    stage_nxt_s = stage_r;
                end
`endif
                default: begin
                    stage_nxt_s = stage_r;
                end
            endcase
        end else begin
            stage_nxt_s = stage_r;
        end
    end

    // Stage array and shifted-out word registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_r <= {(DEPTH*WIDTH){1'b0}};
            sout_r  <= {WIDTH{1'b0}};
        end else begin
            stage_r <= stage_nxt_s;
            sout_r  <= sout_nxt_s;
        end
    end

    shreg_fill_ctr #(
        .DEPTH (DEPTH),
        .FW    (FW)
    ) u_fill_ctr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (inc_s),
        .i_set_full (set_full_s),
        .i_clr      (clr_s),
        .o_fill     (o_fill),
        .o_full     (o_full)
    );

    assign o_q    = stage_r;
    assign o_sout = sout_r;

endmodule

// File: tb/tb_shreg_univ.sv
// Scoreboard bench for shreg_univ: directed cases plus random stimulus against a queue-based model.
module tb_shreg_univ;
    import shreg_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH + 1);

    logic                   i_clk   = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic                   i_en    = 1'b0;
    logic [2:0]             i_mode  = 3'd0;
    logic [WIDTH-1:0]       i_d     = '0;
    logic [DEPTH*WIDTH-1:0] i_pdata = '0;
    logic [DEPTH*WIDTH-1:0] o_q;
    logic [WIDTH-1:0]       o_sout;
    logic [FW-1:0]          o_fill;
    logic                   o_full;

    shreg_univ #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_mode  (i_mode),
        .i_d     (i_d),
        .i_pdata (i_pdata),
        .o_q     (o_q),
        .o_sout  (o_sout),
        .o_fill  (o_fill),
        .o_full  (o_full)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DEPTH*WIDTH-1:0] q;
        logic [WIDTH-1:0]       sout;
        logic [FW-1:0]          fill;
        logic                   full;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] m_stage[$];   // m_stage[k] is stage k
    logic [WIDTH-1:0] m_sout;
    int               m_fill;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_stage = {};
        for (int k = 0; k < DEPTH; k++) m_stage.push_back('0);
        m_sout = '0;
        m_fill = 0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        for (int k = 0; k < DEPTH; k++) e.q[k*WIDTH +: WIDTH] = m_stage[k];
        e.sout = m_sout;
        e.fill = FW'(m_fill);
        e.full = (m_fill == DEPTH);
        return e;
    endfunction

    function automatic void model_step(input logic en, input logic [2:0] mode,
                                       input logic [WIDTH-1:0] d, input logic [DEPTH*WIDTH-1:0] pd);
        logic [WIDTH-1:0] t;
        if (!en) return;
        case (mode)
            3'd1: begin
                m_sout = m_stage.pop_back();
                m_stage.push_front(d);
                if (m_fill < DEPTH) m_fill++;
            end
            3'd2: begin
                m_sout = m_stage.pop_front();
                m_stage.push_back(d);
                if (m_fill < DEPTH) m_fill++;
            end
            3'd3: begin
                for (int k = 0; k < DEPTH; k++) m_stage[k] = pd[k*WIDTH +: WIDTH];
                m_fill = DEPTH;
            end
            3'd4: begin
                for (int k = 0; k < DEPTH; k++) m_stage[k] = '0;
                m_sout = '0;
                m_fill = 0;
            end
`ifdef SHREG_ROTATE_EN
            3'd5: begin
                t = m_stage.pop_back();
                m_stage.push_front(t);
            end
            3'd6: begin
                t = m_stage.pop_front();
                m_stage.push_back(t);
            end
`endif
            default: ;
        endcase
    endfunction

    task automatic issue(input logic en, input logic [2:0] mode,
                         input logic [WIDTH-1:0] d, input logic [DEPTH*WIDTH-1:0] pd);
        @(negedge i_clk);
        i_en    = en;
        i_mode  = mode;
        i_d     = d;
        i_pdata = pd;
        model_step(en, mode, d, pd);
        sb_q.push_back(model_expect());
    endtask

    task automatic settle();
        @(posedge i_clk);
        #2;
    endtask

    // Monitor: one expected entry per issued cycle, compared just after the edge.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_q",    o_q,    e.q);
            chk("sb_sout", o_sout, e.sout);
            chk("sb_fill", o_fill, e.fill);
            chk("sb_full", o_full, e.full);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          guard;
        model_reset();
        #12;
        chk("reset_q",    o_q,    16'h0);
        chk("reset_sout", o_sout, 4'h0);
        chk("reset_fill", o_fill, 3'd0);
        chk("reset_full", o_full, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fill from reset, then one more shift with the register full.
        for (int i = 1; i <= 4; i++) issue(1'b1, 3'd1, 4'(i), 16'h0);
        settle();
        chk("t1_q",    o_q,    16'h1234);
        chk("t1_fill", o_fill, 3'd4);
        chk("t1_full", o_full, 1'b1);
        issue(1'b1, 3'd1, 4'h5, 16'h0);
        settle();
        chk("t1b_q",    o_q,    16'h2345);
        chk("t1b_sout", o_sout, 4'h1);
        chk("t1b_fill", o_fill, 3'd4);

        issue(1'b1, 3'd4, 4'h0, 16'h0);
        settle();
        chk("t5_q",    o_q,    16'h0);
        chk("t5_sout", o_sout, 4'h0);
        chk("t5_fill", o_fill, 3'd0);
        chk("t5_full", o_full, 1'b0);

        issue(1'b1, 3'd3, 4'h0, 16'h4321);
        issue(1'b1, 3'd2, 4'hF, 16'h0);
        settle();
        chk("t2_q",    o_q,    16'hF432);
        chk("t2_sout", o_sout, 4'h1);
        chk("t2_fill", o_fill, 3'd4);

        issue(1'b1, 3'd3, 4'h0, 16'h4321);
        issue(1'b1, 3'd5, 4'h0, 16'h0);
        settle();
`ifdef SHREG_ROTATE_EN
        chk("t3_q", o_q, 16'h3214);
`else
        chk("t3_q", o_q, 16'h4321);
`endif
        chk("t3_sout", o_sout, 4'h1);

        // Disabled shifts and the reserved mode must leave everything alone.
        for (int i = 0; i < 3; i++) issue(1'b0, 3'd1, 4'hA, 16'hFFFF);
        issue(1'b1, 3'd7, 4'hA, 16'hFFFF);
        settle();
`ifdef SHREG_ROTATE_EN
        chk("t4_q", o_q, 16'h3214);
`else
        chk("t4_q", o_q, 16'h4321);
`endif
        chk("t4_sout", o_sout, 4'h1);
        chk("t4_fill", o_fill, 3'd4);

        // Asynchronous reset in the middle of a shift stream.
        issue(1'b1, 3'd4, 4'h0, 16'h0);
        for (int i = 0; i < 3; i++) issue(1'b1, 3'd1, 4'(i + 7), 16'h0);
        settle();
        i_rst_n = 1'b0;
        #1;
        chk("t6_q",    o_q,    16'h0);
        chk("t6_sout", o_sout, 4'h0);
        chk("t6_fill", o_fill, 3'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        chk("t6_hold_q", o_q, 16'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_en    = 1'b0;
        issue(1'b1, 3'd1, 4'h3, 16'h0);
        issue(1'b1, 3'd1, 4'h6, 16'h0);
        settle();
        chk("t6_fill2", o_fill, 3'd2);
        chk("t6_q2",    o_q,    16'h0036);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            issue((r[31:29] != 3'd0), r[2:0], r[7:4], r[23:8]);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge i_clk);
            guard++;
        end
        #2;
        chk("scoreboard_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
